mem_access: RTL and testbench
=============================

MEM_ACCESS -- requirements
Module: mem_access

Interface
REQ-001 SHALL have ports, clock and reset first: clk  in  1  sole clock, all state on rising edge; rst_n  in  1  asynchronous active-low reset.
REQ-002 SHALL have EX/MEM-side inputs: i_MemRead 1 load; i_MemWrite 1 store; i_MemtoReg 1 writeback select; i_RegWrite 1 writeback enable; i_alu_out 32 address/ALU result; i_alu_b 32 store data; i_dest 5 destination register; i_flush 1 kill current op.
REQ-003 SHALL have data-memory outputs: dm_req 1 request; dm_we 1 write enable; dm_addr 32; dm_wdata 32.
REQ-004 SHALL have data-memory inputs: dm_rdata 32 read data; dm_ack 1 completion, valid only while dm_req=1.
REQ-005 SHALL have MEM/WB outputs: stall 1 hold upstream; o_RegWrite 1; o_MemtoReg 1; o_dest 5; o_alu_out 32; o_rdata 32; o_err 1 sticky timeout flag.
REQ-006 SHALL use parameter TIMEOUT, default 15, meaning maximum ACCESS cycles before abort.

Function
REQ-007 SHALL implement states IDLE and ACCESS.
REQ-008 In IDLE with neither i_MemRead nor i_MemWrite, SHALL register i_RegWrite/i_MemtoReg/i_dest/i_alu_out into outputs next edge (1-cycle latency), o_rdata unchanged, stall=0.
REQ-009 In IDLE with i_MemRead or i_MemWrite and i_flush=0, SHALL assert stall combinationally that cycle, latch dm_addr=i_alu_out, dm_wdata=i_alu_b, dm_we=i_MemWrite, and enter ACCESS with dm_req=1 from next edge.
REQ-010 If i_MemRead and i_MemWrite both high, SHALL treat the op as a store.
REQ-011 With i_flush=1 in IDLE, SHALL issue no memory request and load a bubble (o_RegWrite=0, o_dest=0).
REQ-012 In ACCESS, SHALL hold dm_req, dm_we, dm_addr, dm_wdata stable and stall=1 until dm_ack or timeout; i_flush ignored.
REQ-013 On edge with dm_req=1 and dm_ack=1, SHALL load o_rdata=dm_rdata (load) or keep it (store), load latched writeback controls and dest, drop dm_req, return to IDLE; stall=0 in the following cycle.
REQ-014 Earliest completion SHALL be one cycle after dm_req rises; total load latency = ack cycle + 1.
REQ-015 While stall=1, SHALL drive o_RegWrite=0 each edge so no writeback repeats.
REQ-016 SHALL count ACCESS cycles in a counter cleared on ACCESS entry; when count reaches TIMEOUT without ack, SHALL drop dm_req, set o_err=1, load a bubble, return to IDLE.
REQ-017 o_err SHALL remain 1 until reset.
REQ-018 Upstream SHALL keep inputs stable while stall=1; block SHALL re-sample only in IDLE.

Reset
REQ-019 On rst_n=0, asynchronously: state=IDLE, counter=0, dm_req=0, dm_we=0, dm_addr=0, dm_wdata=0, stall=0, all o_* =0, o_err=0.
REQ-020 Reset during ACCESS SHALL abandon the transaction; dm_req low immediately.

Structure
REQ-021 State encoding and TIMEOUT default SHALL live in shared package pipeline_pkg.
REQ-022 SHALL be a single module; timeout counter inline, no sub-module.

Verification
REQ-023 ALU op: i_alu_out=0x1234, i_dest=5, i_RegWrite=1 -> next edge o_alu_out=0x1234, o_dest=5, o_RegWrite=1, stall never high.
REQ-024 Load: i_MemRead=1, i_alu_out=0x40, ack 3 cycles after dm_req with dm_rdata=0xDEADBEEF -> dm_addr=0x40, stall high 4 cycles, o_rdata=0xDEADBEEF, o_RegWrite pulses once.
REQ-025 Store: i_MemWrite=1, i_alu_b=0xA5A5A5A5, ack after 1 cycle -> dm_we=1, dm_wdata=0xA5A5A5A5, o_RegWrite=0, o_rdata unchanged.
REQ-026 Timeout: load, dm_ack held 0 -> dm_req drops after 15 ACCESS cycles, o_err=1 persistent, bubble loaded.
REQ-027 Flush: i_MemRead=1 with i_flush=1 -> dm_req stays 0, o_RegWrite=0; flush during ACCESS -> transaction still completes.
REQ-028 Reset mid-ACCESS: rst_n low 2 cycles after dm_req rises -> dm_req, stall, all outputs 0 immediately; next op proceeds normally.

Source files
------------

// File: rtl/pipeline_pkg.sv
// Shared definitions for the pipeline MEM stage: FSM state encoding and
// the default data-memory timeout.
package pipeline_pkg;

  typedef enum logic [0:0] {
    ST_IDLE   = 1'b0,
    ST_ACCESS = 1'b1
  } mem_state_e;

  localparam int unsigned TIMEOUT_DEFAULT = 15;

endpackage

// File: rtl/mem_access.sv
// MEM pipeline stage: passes ALU results to MEM/WB and runs loads/stores on
// a req/ack data-memory port, stalling upstream while a transaction is open.
module mem_access
  import pipeline_pkg::*;
#(
  parameter int unsigned TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_MemRead,
  input  logic        i_MemWrite,
  input  logic        i_MemtoReg,
  input  logic        i_RegWrite,
  input  logic [31:0] i_alu_out,
  input  logic [31:0] i_alu_b,
  input  logic [4:0]  i_dest,
  input  logic        i_flush,
  output logic        dm_req,
  output logic        dm_we,
  output logic [31:0] dm_addr,
  output logic [31:0] dm_wdata,
  input  logic [31:0] dm_rdata,
  input  logic        dm_ack,
  output logic        stall,
  output logic        o_RegWrite,
  output logic        o_MemtoReg,
  output logic [4:0]  o_dest,
  output logic [31:0] o_alu_out,
  output logic [31:0] o_rdata,
  output logic        o_err
);

  localparam int unsigned    CW       = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0]  CNT_ONE  = CW'(1);
  localparam logic [CW-1:0]  CNT_LAST = CW'(TIMEOUT - 1);

  mem_state_e    r_state;
  mem_state_e    w_next_state;
  logic [CW-1:0] r_cnt;
  logic          w_start;
  logic          w_done;
  logic          w_timeout;
  logic          w_stall;

  logic          r_dm_req;
  logic          r_dm_we;
  logic [31:0]   r_dm_addr;
  logic [31:0]   r_dm_wdata;

  logic          r_lat_rw;
  logic          r_lat_m2r;
  logic [4:0]    r_lat_dest;
  logic [31:0]   r_lat_alu;
  logic          r_lat_load;

  logic          r_rw;
  logic          r_m2r;
  logic [4:0]    r_dest;
  logic [31:0]   r_alu;
  logic [31:0]   r_rdata;
  logic          r_err;

  // A store wins when both read and write are requested.
  assign w_start   = (r_state == ST_IDLE) && (i_MemRead || i_MemWrite) && !i_flush;
  assign w_done    = (r_state == ST_ACCESS) && dm_ack;
  assign w_timeout = (r_state == ST_ACCESS) && !dm_ack && (r_cnt == CNT_LAST);

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // FSM next-state logic
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE:   w_next_state = w_start ? ST_ACCESS : ST_IDLE;
      ST_ACCESS: w_next_state = (w_done || w_timeout) ? ST_IDLE : ST_ACCESS;
      default:   w_next_state = ST_IDLE;
    endcase
  end

  // FSM output logic: stall rises in the same cycle a memory op is seen
  always_comb begin
    w_stall = 1'b0;
    case (r_state)
      ST_IDLE:   w_stall = w_start;
      ST_ACCESS: w_stall = 1'b1;
      default:   w_stall = 1'b0;
    endcase
  end

  assign stall = rst_n & w_stall;

  // ACCESS cycle counter, restarted on every transaction
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (w_start) begin
      r_cnt <= '0;
    end else if (r_state == ST_ACCESS) begin
      r_cnt <= r_cnt + CNT_ONE;
    end
  end

  // Data-memory request registers and latched writeback controls
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_dm_req   <= 1'b0;
      r_dm_we    <= 1'b0;
      r_dm_addr  <= 32'd0;
      r_dm_wdata <= 32'd0;
      r_lat_rw   <= 1'b0;
      r_lat_m2r  <= 1'b0;
      r_lat_dest <= 5'd0;
      r_lat_alu  <= 32'd0;
      r_lat_load <= 1'b0;
    end else if (w_start) begin
      r_dm_req   <= 1'b1;
      r_dm_we    <= i_MemWrite;
      r_dm_addr  <= i_alu_out;
      r_dm_wdata <= i_alu_b;
      r_lat_rw   <= i_RegWrite;
      r_lat_m2r  <= i_MemtoReg;
      r_lat_dest <= i_dest;
      r_lat_alu  <= i_alu_out;
      r_lat_load <= !i_MemWrite;
    end else if (w_done || w_timeout) begin
      r_dm_req <= 1'b0;
      r_dm_we  <= 1'b0;
    end
  end

  // MEM/WB output registers; a bubble clears writeback, dest and ALU result
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rw    <= 1'b0;
      r_m2r   <= 1'b0;
      r_dest  <= 5'd0;
      r_alu   <= 32'd0;
      r_rdata <= 32'd0;
      r_err   <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (i_flush) begin
            r_rw   <= 1'b0;
            r_m2r  <= 1'b0;
            r_dest <= 5'd0;
            r_alu  <= 32'd0;
          end else if (i_MemRead || i_MemWrite) begin
            r_rw <= 1'b0;
          end else begin
            r_rw   <= i_RegWrite;
            r_m2r  <= i_MemtoReg;
            r_dest <= i_dest;
            r_alu  <= i_alu_out;
          end
        end
        ST_ACCESS: begin
          if (dm_ack) begin
            r_rw   <= r_lat_rw;
            r_m2r  <= r_lat_m2r;
            r_dest <= r_lat_dest;
            r_alu  <= r_lat_alu;
            if (r_lat_load) begin
              r_rdata <= dm_rdata;
            end
          end else if (w_timeout) begin
            r_rw   <= 1'b0;
            r_m2r  <= 1'b0;
            r_dest <= 5'd0;
            r_alu  <= 32'd0;
            r_err  <= 1'b1;
          end else begin
            r_rw <= 1'b0;
          end
        end
        default: r_rw <= 1'b0;
      endcase
    end
  end

  assign dm_req     = r_dm_req;
  assign dm_we      = r_dm_we;
  assign dm_addr    = r_dm_addr;
  assign dm_wdata   = r_dm_wdata;
  assign o_RegWrite = r_rw;
  assign o_MemtoReg = r_m2r;
  assign o_dest     = r_dest;
  assign o_alu_out  = r_alu;
  assign o_rdata    = r_rdata;
  assign o_err      = r_err;

endmodule

// File: tb/tb_mem_access.sv
// Self-checking bench for mem_access: table-driven ALU/flush vectors plus
// hand-written load/store/timeout/reset sequences, all scored via a queue.
module tb_mem_access;
  import pipeline_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        i_MemRead = 1'b0, i_MemWrite = 1'b0, i_MemtoReg = 1'b0, i_RegWrite = 1'b0;
  logic [31:0] i_alu_out = 32'd0, i_alu_b = 32'd0;
  logic [4:0]  i_dest = 5'd0;
  logic        i_flush = 1'b0;
  logic        dm_req, dm_we;
  logic [31:0] dm_addr, dm_wdata;
  logic [31:0] dm_rdata = 32'd0;
  logic        dm_ack = 1'b0;
  logic        stall, o_RegWrite, o_MemtoReg, o_err;
  logic [4:0]  o_dest;
  logic [31:0] o_alu_out, o_rdata;

  mem_access #(.TIMEOUT(15)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_MemRead(i_MemRead), .i_MemWrite(i_MemWrite), .i_MemtoReg(i_MemtoReg),
    .i_RegWrite(i_RegWrite), .i_alu_out(i_alu_out), .i_alu_b(i_alu_b),
    .i_dest(i_dest), .i_flush(i_flush),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_rdata(dm_rdata), .dm_ack(dm_ack),
    .stall(stall), .o_RegWrite(o_RegWrite), .o_MemtoReg(o_MemtoReg),
    .o_dest(o_dest), .o_alu_out(o_alu_out), .o_rdata(o_rdata), .o_err(o_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rw;
    logic        m2r;
    logic [4:0]  dest;
    logic [31:0] alu;
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  typedef struct {
    logic        rw;
    logic        m2r;
    logic [4:0]  dest;
    logic [31:0] alu;
    logic        flush;
    logic        rd;
    logic        e_rw;
    logic        e_m2r;
    logic [4:0]  e_dest;
    logic [31:0] e_alu;
  } vec_t;

  exp_t        sb[$];
  vec_t        vt[6];
  int          total = 0;
  int          bad = 0;
  logic [31:0] m_rdata = 32'd0;
  logic        m_err = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask

  task automatic sb_check(input string tag);
    exp_t e;
    if (sb.size() == 0) begin
      total++;
      bad++;
      $display("FAIL %s: scoreboard empty, got rw=%b dest=%0d", tag, o_RegWrite, o_dest);
    end else begin
      e = sb.pop_front();
      check($sformatf("%s.RegWrite", tag), 32'(o_RegWrite), 32'(e.rw));
      check($sformatf("%s.MemtoReg", tag), 32'(o_MemtoReg), 32'(e.m2r));
      check($sformatf("%s.dest", tag), 32'(o_dest), 32'(e.dest));
      check($sformatf("%s.alu_out", tag), o_alu_out, e.alu);
      check($sformatf("%s.rdata", tag), o_rdata, e.rdata);
      check($sformatf("%s.err", tag), 32'(o_err), 32'(e.err));
    end
  endtask

  task automatic set_in(input logic rd, input logic wr, input logic rw, input logic m2r,
                        input logic [4:0] dest, input logic [31:0] alu, input logic [31:0] b,
                        input logic fl);
    i_MemRead  = rd;
    i_MemWrite = wr;
    i_RegWrite = rw;
    i_MemtoReg = m2r;
    i_dest     = dest;
    i_alu_out  = alu;
    i_alu_b    = b;
    i_flush    = fl;
  endtask

  // d = ack delay in cycles after dm_req rises; 0 means never acknowledge
  task automatic mem_op(input string tag, input logic st, input logic both,
                        input logic [31:0] addr, input logic [31:0] wd, input logic [4:0] dest,
                        input logic rw, input logic m2r, input int d,
                        input logic [31:0] rd_data, input logic flush_mid);
    int   nstall;
    int   nreq;
    logic stable;
    logic tmo;
    tmo = (d == 0) || (d > 15);
    @(negedge clk);
    set_in(st ? both : 1'b1, st, rw, m2r, dest, addr, wd, 1'b0);
    if (tmo) begin
      m_err = 1'b1;
      sb.push_back('{1'b0, 1'b0, 5'd0, 32'd0, m_rdata, 1'b1});
    end else begin
      if (!st) m_rdata = rd_data;
      sb.push_back('{rw, m2r, dest, addr, m_rdata, m_err});
    end
    #1;
    nstall = stall ? 1 : 0;
    @(posedge clk); #1;
    check($sformatf("%s.req_rise", tag), 32'(dm_req), 32'd1);
    check($sformatf("%s.addr", tag), dm_addr, addr);
    check($sformatf("%s.we", tag), 32'(dm_we), 32'(st));
    if (st) check($sformatf("%s.wdata", tag), dm_wdata, wd);
    nreq = 1;
    stable = 1'b1;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      if (stall) nstall++;
      if (flush_mid && c == 1) i_flush = 1'b1;
      dm_ack   = (c == d);
      dm_rdata = (c == d) ? rd_data : 32'hBAD0_BAD0;
      @(posedge clk); #1;
      if (!dm_req) break;
      nreq++;
      if (dm_addr !== addr || dm_we !== st || dm_wdata !== wd || o_RegWrite !== 1'b0)
        stable = 1'b0;
    end
    check($sformatf("%s.stall_cycles", tag), 32'(nstall), tmo ? 32'd16 : 32'(d + 1));
    check($sformatf("%s.req_cycles", tag), 32'(nreq), tmo ? 32'd15 : 32'(d));
    check($sformatf("%s.held_stable", tag), 32'(stable), 32'd1);
    check($sformatf("%s.req_drop", tag), 32'(dm_req), 32'd0);
    sb_check(tag);
    @(negedge clk);
    dm_ack = 1'b0;
    set_in(1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0000_00A0, 32'd0, 1'b0);
    sb.push_back('{1'b0, 1'b0, 5'd0, 32'h0000_00A0, m_rdata, m_err});
    #1;
    check($sformatf("%s.stall_after", tag), 32'(stall), 32'd0);
    @(posedge clk); #1;
    sb_check($sformatf("%s.next", tag));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vt[0] = '{1'b1, 1'b0, 5'd5,  32'h0000_1234, 1'b0, 1'b0, 1'b1, 1'b0, 5'd5,  32'h0000_1234};
    vt[1] = '{1'b1, 1'b1, 5'd31, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b1, 1'b1, 5'd31, 32'hFFFF_FFFF};
    vt[2] = '{1'b0, 1'b0, 5'd0,  32'h0000_0000, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0,  32'h0000_0000};
    vt[3] = '{1'b1, 1'b0, 5'd12, 32'h8000_0001, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0,  32'h0000_0000};
    vt[4] = '{1'b1, 1'b0, 5'd9,  32'h55AA_55AA, 1'b0, 1'b0, 1'b1, 1'b0, 5'd9,  32'h55AA_55AA};
    vt[5] = '{1'b1, 1'b1, 5'd3,  32'h0000_0040, 1'b1, 1'b1, 1'b0, 1'b0, 5'd0,  32'h0000_0000};

    // reset state
    #12;
    check("rst.dm_req", 32'(dm_req), 32'd0);
    check("rst.dm_we", 32'(dm_we), 32'd0);
    check("rst.dm_addr", dm_addr, 32'd0);
    check("rst.stall", 32'(stall), 32'd0);
    sb.push_back('{1'b0, 1'b0, 5'd0, 32'd0, 32'd0, 1'b0});
    sb_check("rst");
    @(negedge clk);
    rst_n = 1'b1;

    // IDLE pass-through and flush vectors
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      set_in(vt[i].rd, 1'b0, vt[i].rw, vt[i].m2r, vt[i].dest, vt[i].alu, 32'h1111_2222, vt[i].flush);
      sb.push_back('{vt[i].e_rw, vt[i].e_m2r, vt[i].e_dest, vt[i].e_alu, m_rdata, m_err});
      #1;
      check($sformatf("vec%0d.stall", i), 32'(stall), 32'd0);
      @(posedge clk); #1;
      sb_check($sformatf("vec%0d", i));
      check($sformatf("vec%0d.dm_req", i), 32'(dm_req), 32'd0);
    end

    mem_op("load",      1'b0, 1'b0, 32'h0000_0040, 32'h0,         5'd7,  1'b1, 1'b1, 3, 32'hDEAD_BEEF, 1'b0);
    mem_op("store",     1'b1, 1'b0, 32'h0000_0080, 32'hA5A5_A5A5, 5'd8,  1'b0, 1'b0, 1, 32'h0,         1'b0);
    mem_op("rdwr",      1'b1, 1'b1, 32'h0000_00C4, 32'h0F0F_1234, 5'd0,  1'b0, 1'b0, 2, 32'h0,         1'b0);
    mem_op("flush_mid", 1'b0, 1'b0, 32'h0000_0100, 32'h0,         5'd9,  1'b1, 1'b1, 2, 32'h0BAD_F00D, 1'b1);
    mem_op("timeout",   1'b0, 1'b0, 32'h0000_0200, 32'h0,         5'd4,  1'b1, 1'b1, 0, 32'h0,         1'b0);
    mem_op("after_tmo", 1'b1, 1'b0, 32'h0000_0300, 32'h1357_9BDF, 5'd1,  1'b0, 1'b0, 1, 32'h0,         1'b0);

    // reset while a load is outstanding
    @(negedge clk);
    set_in(1'b1, 1'b0, 1'b1, 1'b1, 5'd2, 32'h0000_0400, 32'd0, 1'b0);
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("rstmid.dm_req", 32'(dm_req), 32'd0);
    check("rstmid.stall", 32'(stall), 32'd0);
    check("rstmid.dm_addr", dm_addr, 32'd0);
    m_rdata = 32'd0;
    m_err = 1'b0;
    sb.push_back('{1'b0, 1'b0, 5'd0, 32'd0, 32'd0, 1'b0});
    sb_check("rstmid");
    repeat (2) @(negedge clk);
    set_in(1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0, 32'd0, 1'b0);
    rst_n = 1'b1;

    mem_op("post_rst", 1'b0, 1'b0, 32'h0000_0500, 32'h0, 5'd6, 1'b1, 1'b1, 2, 32'h1234_5678, 1'b0);

    check("sb.empty", 32'(sb.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
